// File: rtl/ddr2_ctrl_input_gen.sv
// Sequencer between the UM command/data interface and the DDR2 controller
// local port. Writes are split into R=UW/LW beats per user word (MSB slice
// first). Reads are announced once through rd_ddr2_size and then issued as
// bursts of at most BMAX beats, separated by one idle cycle.
module ddr2_ctrl_input_gen #(
  parameter int LW       = 32,
  parameter int UW       = 128,
  parameter int AW       = 26,
  parameter int LEN_W    = 7,
  parameter int BMAX     = 4,
  parameter int ADDR_INC = 8
) (
  input  logic                    ddr2_clk,
  input  logic                    sys_rst_n,
  input  logic                    local_init_done,
  input  logic                    local_ready,
  output logic [AW-1:0]           local_address,
  output logic                    local_write_req,
  output logic                    local_read_req,
  output logic                    local_burstbegin,
  output logic [LW-1:0]           local_wdata,
  output logic [LW/8-1:0]         local_be,
  output logic [3:0]              local_size,
  input  logic                    um2ddr_command_wrreq,
  input  logic [AW+LEN_W:0]       um2ddr_command,
  output logic                    um2ddr_command_ready,
  input  logic                    um2ddr_wrreq,
  input  logic [UW-1:0]           um2ddr_data,
  output logic                    um2ddr_data_ready,
  output logic [LEN_W+$clog2(UW/LW)-1:0] rd_ddr2_size,
  output logic                    rd_ddr2_size_wrreq,
  input  logic                    read_permit,
  output logic                    busy
);

  localparam int R  = UW / LW;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int SW = LEN_W + $clog2(R);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_BEAT, RD_PERMIT, RD_REQ, RD_GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [SW-1:0]     rem_reg, rem_next;
  logic [RW-1:0]     beat_reg, beat_next;
  logic [UW-1:0]     word_reg, word_next;
  logic              ready_en_reg;

  // Command fields: {rd, len, addr}
  logic              cmd_rd;
  logic [LEN_W-1:0]  cmd_len;
  logic [AW-1:0]     cmd_addr;
  assign cmd_rd   = um2ddr_command[AW+LEN_W];
  assign cmd_len  = um2ddr_command[AW+LEN_W-1:AW];
  assign cmd_addr = um2ddr_command[AW-1:0];

  // Helpers: a beat/request completes only while calibration is done.
  logic              xfer_ok;
  logic [SW-1:0]     rd_total;
  logic [3:0]        burst;
  logic [SW-1:0]     rem_after;
  logic [UW-1:0]     word_shift;

  // State register; ready_en_reg keeps command_ready low in the reset cycle.
  always_ff @(posedge ddr2_clk) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      rem_reg      <= '0;
      beat_reg     <= '0;
      word_reg     <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      rem_reg      <= rem_next;
      beat_reg     <= beat_next;
      word_reg     <= word_next;
      ready_en_reg <= 1'b1;
    end
  end

  // Next-state logic and all port outputs, decoded from the current state.
  always_comb begin
    state_next           = state_reg;
    addr_next            = addr_reg;
    len_next             = len_reg;
    rem_next             = rem_reg;
    beat_next            = beat_reg;
    word_next            = word_reg;
    local_address        = '0;
    local_write_req      = 1'b0;
    local_read_req       = 1'b0;
    local_burstbegin     = 1'b0;
    local_wdata          = '0;
    local_be             = '0;
    local_size           = '0;
    um2ddr_command_ready = 1'b0;
    um2ddr_data_ready    = 1'b0;
    rd_ddr2_size         = '0;
    rd_ddr2_size_wrreq   = 1'b0;
    busy                 = (state_reg != IDLE);

    xfer_ok    = local_ready & local_init_done;
    rd_total   = SW'(len_reg) * SW'(R);
    burst      = (rem_reg < SW'(BMAX)) ? 4'(rem_reg) : 4'(BMAX);
    rem_after  = rem_reg - SW'(burst);
    word_shift = word_reg >> (LW * (R - 1 - int'(beat_reg)));

    case (state_reg)
      IDLE: begin
        um2ddr_command_ready = local_init_done & ready_en_reg;
        if (um2ddr_command_ready && um2ddr_command_wrreq) begin
          addr_next = cmd_addr;
          len_next  = cmd_len;
          beat_next = '0;
          // A zero-length command is consumed without any local traffic.
          if (cmd_len != '0) begin
            state_next = cmd_rd ? RD_PERMIT : WR_DATA;
          end
        end
      end

      WR_DATA: begin
        um2ddr_data_ready = 1'b1;
        if (um2ddr_wrreq) begin
          word_next  = um2ddr_data;
          beat_next  = '0;
          state_next = WR_BEAT;
        end
      end

      WR_BEAT: begin
        local_write_req  = 1'b1;
        local_burstbegin = (beat_reg == '0);
        local_address    = addr_reg;
        local_be         = '1;
        local_size       = 4'(R);
        local_wdata      = word_shift[LW-1:0];
        if (xfer_ok) begin
          if (beat_reg == RW'(R - 1)) begin
            beat_next  = '0;
            addr_next  = addr_reg + AW'(ADDR_INC);
            len_next   = len_reg - LEN_W'(1);
            state_next = (len_reg == LEN_W'(1)) ? IDLE : WR_DATA;
          end else begin
            beat_next = beat_reg + RW'(1);
          end
        end
      end

      RD_PERMIT: begin
        if (read_permit) begin
          rd_ddr2_size_wrreq = 1'b1;
          rd_ddr2_size       = rd_total;
          rem_next           = rd_total;
          state_next         = RD_REQ;
        end
      end

      RD_REQ: begin
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        local_address    = addr_reg;
        local_be         = '1;
        local_size       = burst;
        if (xfer_ok) begin
          rem_next   = rem_after;
          addr_next  = addr_reg + AW'(ADDR_INC);
          state_next = (rem_after == '0) ? IDLE : RD_GAP;
        end
      end

      RD_GAP: begin
        state_next = RD_REQ;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ddr2_ctrl_input_gen.sv
// Directed bench for ddr2_ctrl_input_gen. Two instances share stimulus
// (BMAX=4 and BMAX=3); a transaction-level model predicts every completed
// local transfer and size strobe, and a per-cycle monitor checks them.
`timescale 1ns/1ps
module tb_ddr2_ctrl_input_gen;
  localparam int LW = 32, UW = 128, AW = 26, LEN_W = 7, SW = 9;

  logic ddr2_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic local_init_done = 1'b0;
  logic local_ready = 1'b0;
  logic um2ddr_command_wrreq = 1'b0;
  logic [AW+LEN_W:0] um2ddr_command = '0;
  logic um2ddr_wrreq = 1'b0;
  logic [UW-1:0] um2ddr_data = '0;
  logic read_permit = 1'b0;

  logic [AW-1:0] addr_o [2];
  logic          wr_o [2];
  logic          rd_o [2];
  logic          bb_o [2];
  logic [LW-1:0] wdata_o [2];
  logic [3:0]    be_o [2];
  logic [3:0]    size_o [2];
  logic          cmd_rdy [2];
  logic          data_rdy [2];
  logic [SW-1:0] rsz [2];
  logic          rsz_stb [2];
  logic          busy_o [2];

  always #5 ddr2_clk = ~ddr2_clk;

  // Instance 0 uses BMAX=4, instance 1 uses BMAX=3.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ddr2_ctrl_input_gen #(
      .LW(LW), .UW(UW), .AW(AW), .LEN_W(LEN_W),
      .BMAX((gi == 0) ? 4 : 3), .ADDR_INC(8)
    ) dut (
      .ddr2_clk             (ddr2_clk),
      .sys_rst_n            (sys_rst_n),
      .local_init_done      (local_init_done),
      .local_ready          (local_ready),
      .local_address        (addr_o[gi]),
      .local_write_req      (wr_o[gi]),
      .local_read_req       (rd_o[gi]),
      .local_burstbegin     (bb_o[gi]),
      .local_wdata          (wdata_o[gi]),
      .local_be             (be_o[gi]),
      .local_size           (size_o[gi]),
      .um2ddr_command_wrreq (um2ddr_command_wrreq),
      .um2ddr_command       (um2ddr_command),
      .um2ddr_command_ready (cmd_rdy[gi]),
      .um2ddr_wrreq         (um2ddr_wrreq),
      .um2ddr_data          (um2ddr_data),
      .um2ddr_data_ready    (data_rdy[gi]),
      .rd_ddr2_size         (rsz[gi]),
      .rd_ddr2_size_wrreq   (rsz_stb[gi]),
      .read_permit          (read_permit),
      .busy                 (busy_o[gi])
    );
  end

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic [3:0]    size;
    logic          bb;
  } xfer_t;

  int n_checks = 0;
  int n_fail = 0;

  xfer_t exp0[$], exp1[$];
  int    sexp0[$], sexp1[$];
  xfer_t obs0[$], obs1[$];
  int    hold0[$];
  int    sobs0[$], sobs1[$];
  int    strobe_cnt [2] = '{0, 0};
  int    done_cnt [2] = '{0, 0};
  logic  held [2] = '{1'b0, 1'b0};
  logic  gap_need [2] = '{1'b0, 1'b0};
  int    hcnt [2] = '{0, 0};
  logic [64:0] prev_vec [2];
  logic [UW-1:0] wbuf [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string nm(input string s, input int d);
    return $sformatf("%s_dut%0d", s, d);
  endfunction

  // Model: every user word becomes 4 beats at the word's address, MSB first.
  task automatic model_write(input logic [AW-1:0] a, input int len);
    xfer_t e;
    logic [UW-1:0] w;
    logic [AW-1:0] wa;
    wa = a;
    for (int i = 0; i < len; i++) begin
      w = wbuf[i];
      for (int k = 0; k < 4; k++) begin
        e.rd = 1'b0; e.addr = wa; e.data = w[127-32*k -: 32];
        e.size = 4'd4; e.bb = (k == 0);
        exp0.push_back(e); exp1.push_back(e);
      end
      wa = wa + 26'd8;
    end
  endtask

  // Model: len*4 beats announced once, then bursts of min(remaining, BMAX).
  task automatic model_read(input logic [AW-1:0] a, input int len);
    xfer_t e;
    int rem, bm, s;
    logic [AW-1:0] ra;
    if (len == 0) return;
    for (int d = 0; d < 2; d++) begin
      bm = (d == 0) ? 4 : 3;
      rem = len * 4;
      ra = a;
      if (d == 0) sexp0.push_back(len * 4); else sexp1.push_back(len * 4);
      while (rem > 0) begin
        s = (rem < bm) ? rem : bm;
        e.rd = 1'b1; e.addr = ra; e.data = '0; e.size = 4'(s); e.bb = 1'b1;
        if (d == 0) exp0.push_back(e); else exp1.push_back(e);
        rem -= s;
        ra = ra + 26'd8;
      end
    end
  endtask

  // Per-cycle check of one instance just before the rising edge.
  task automatic mon(input int d);
    xfer_t cur, e;
    logic req, done, have;
    logic [64:0] vec;
    int sv;
    if (!sys_rst_n) begin
      held[d] = 1'b0; hcnt[d] = 0; gap_need[d] = 1'b0;
      return;
    end
    cur.rd = rd_o[d]; cur.addr = addr_o[d]; cur.data = wdata_o[d];
    cur.size = size_o[d]; cur.bb = bb_o[d];
    req = wr_o[d] | rd_o[d];
    vec = {wr_o[d], rd_o[d], addr_o[d], wdata_o[d], size_o[d], bb_o[d]};
    if (req) chk(nm("be_active", d), 128'(be_o[d]), 128'hF);
    if (gap_need[d]) chk(nm("req_gap", d), 128'(req), 128'h0);
    gap_need[d] = 1'b0;
    if (held[d]) chk(nm("req_hold", d), 128'(vec), 128'(prev_vec[d]));
    if (req) hcnt[d]++;
    done = req & local_ready & local_init_done;
    if (done) begin
      done_cnt[d]++;
      have = 1'b0;
      if (d == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
      if (d == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
      chk(nm("xfer_expected", d), 128'(have), 128'h1);
      if (have) begin
        chk(nm("xfer_rd", d), 128'(cur.rd), 128'(e.rd));
        chk(nm("xfer_addr", d), 128'(cur.addr), 128'(e.addr));
        chk(nm("xfer_size", d), 128'(cur.size), 128'(e.size));
        chk(nm("xfer_bb", d), 128'(cur.bb), 128'(e.bb));
        if (!e.rd) chk(nm("xfer_wdata", d), 128'(cur.data), 128'(e.data));
        // Reads always gap after a request; writes gap after the 4th beat.
        if (e.rd) gap_need[d] = 1'b1;
        else if ((d == 0 ? exp0.size() : exp1.size()) % 4 == 0) gap_need[d] = 1'b1;
      end
      if (d == 0) begin obs0.push_back(cur); hold0.push_back(hcnt[d]); end
      else obs1.push_back(cur);
      hcnt[d] = 0;
    end
    held[d] = req & ~done;
    prev_vec[d] = vec;
    if (rsz_stb[d]) begin
      strobe_cnt[d]++;
      sv = -1;
      if (d == 0 && sexp0.size() > 0) sv = sexp0.pop_front();
      if (d == 1 && sexp1.size() > 0) sv = sexp1.pop_front();
      chk(nm("size_strobe", d), 128'(rsz[d]), 128'(sv));
      if (d == 0) sobs0.push_back(int'(rsz[d])); else sobs1.push_back(int'(rsz[d]));
    end
  endtask

  // Compare process: sample 1 ns before each rising edge.
  always begin
    @(negedge ddr2_clk);
    #4;
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic wait_cmd_ready();
    int t = 0;
    while (!(cmd_rdy[0] & cmd_rdy[1]) && t < 500) begin @(negedge ddr2_clk); t++; end
    chk("cmd_ready_wait", 128'(cmd_rdy[0] & cmd_rdy[1]), 128'h1);
  endtask

  task automatic send_cmd(input logic rd, input int len, input logic [AW-1:0] a);
    wait_cmd_ready();
    um2ddr_command = {rd, LEN_W'(len), a};
    um2ddr_command_wrreq = 1'b1;
    @(negedge ddr2_clk);
    um2ddr_command_wrreq = 1'b0;
  endtask

  task automatic send_word(input logic [UW-1:0] w);
    int t = 0;
    while (!(data_rdy[0] & data_rdy[1]) && t < 500) begin @(negedge ddr2_clk); t++; end
    chk("data_ready_wait", 128'(data_rdy[0] & data_rdy[1]), 128'h1);
    um2ddr_data = w;
    um2ddr_wrreq = 1'b1;
    @(negedge ddr2_clk);
    um2ddr_wrreq = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_o[0] | busy_o[1]) && t < 500) begin @(negedge ddr2_clk); t++; end
    chk("idle_wait", 128'(busy_o[0] | busy_o[1]), 128'h0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_xfers_left"}, 128'(exp0.size() + exp1.size()), 128'h0);
    chk({tag, "_strobes_left"}, 128'(sexp0.size() + sexp1.size()), 128'h0);
  endtask

  task automatic clear_logs();
    obs0.delete(); obs1.delete(); hold0.delete(); sobs0.delete(); sobs1.delete();
  endtask

  initial begin
    int sc, dc;
    // Reset with calibration not yet done.
    repeat (3) @(negedge ddr2_clk);
    chk("rst_write_req", 128'(wr_o[0]), 128'h0);
    chk("rst_busy", 128'(busy_o[0]), 128'h0);
    chk("rst_cmd_ready", 128'(cmd_rdy[0]), 128'h0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge ddr2_clk);
    chk("no_init_cmd_ready", 128'(cmd_rdy[0]), 128'h0);
    local_init_done = 1'b1;
    local_ready = 1'b1;
    read_permit = 1'b1;
    @(negedge ddr2_clk);
    chk("init_cmd_ready", 128'(cmd_rdy[0]), 128'h1);

    // 1: two-word write with local_ready held high.
    clear_logs();
    wbuf[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    wbuf[1] = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    model_write(26'h100, 2);
    send_cmd(1'b0, 2, 26'h100);
    send_word(wbuf[0]);
    send_word(wbuf[1]);
    wait_idle();
    check_drained("t1");
    chk("t1_beats", 128'(obs0.size()), 128'd8);
    chk("t1_addr_b0", 128'(obs0[0].addr), 128'h100);
    chk("t1_addr_b3", 128'(obs0[3].addr), 128'h100);
    chk("t1_addr_b4", 128'(obs0[4].addr), 128'h108);
    chk("t1_bb_b1", 128'(obs0[1].bb), 128'h0);
    chk("t1_bb_b4", 128'(obs0[4].bb), 128'h1);
    chk("t1_data_b1", 128'(obs0[1].data), 128'h44556677);
    chk("t1_data_b7", 128'(obs0[7].data), 128'hcafef00d);

    // 2: beat 2 stalled for three cycles.
    clear_logs();
    local_ready = 1'b0;
    wbuf[0] = 128'h10101010_20202020_30303030_40404040;
    model_write(26'h200, 1);
    send_cmd(1'b0, 1, 26'h200);
    send_word(wbuf[0]);
    local_ready = 1'b1;
    @(negedge ddr2_clk);
    @(negedge ddr2_clk);
    local_ready = 1'b0;
    repeat (3) @(negedge ddr2_clk);
    local_ready = 1'b1;
    wait_idle();
    check_drained("t2");
    chk("t2_beats", 128'(hold0.size()), 128'd4);
    chk("t2_hold_b0", 128'(hold0[0]), 128'd1);
    chk("t2_hold_b2", 128'(hold0[2]), 128'd4);
    chk("t2_hold_b3", 128'(hold0[3]), 128'd1);
    chk("t2_data_b2", 128'(obs0[2].data), 128'h30303030);

    // 3: 12-beat read waiting on read_permit; stray command/data ignored.
    clear_logs();
    read_permit = 1'b0;
    model_read(26'h300, 3);
    send_cmd(1'b1, 3, 26'h300);
    sc = strobe_cnt[0];
    um2ddr_command = {1'b0, 7'd1, 26'h7};
    um2ddr_command_wrreq = 1'b1;
    um2ddr_data = 128'h5;
    um2ddr_wrreq = 1'b1;
    @(negedge ddr2_clk);
    um2ddr_command_wrreq = 1'b0;
    um2ddr_wrreq = 1'b0;
    repeat (4) @(negedge ddr2_clk);
    chk("t3_no_strobe", 128'(strobe_cnt[0] - sc), 128'd0);
    chk("t3_busy_wait", 128'(busy_o[0]), 128'h1);
    read_permit = 1'b1;
    wait_idle();
    check_drained("t3");
    chk("t3_strobe_val", 128'(sobs0[0]), 128'd12);
    chk("t3_reqs", 128'(obs0.size()), 128'd3);
    chk("t3_size_r0", 128'(obs0[0].size), 128'd4);
    chk("t3_size_r2", 128'(obs0[2].size), 128'd4);
    chk("t3_addr_r1", 128'(obs0[1].addr), 128'h308);
    chk("t3_addr_r2", 128'(obs0[2].addr), 128'h310);

    // 4: one-word read near the top of the address space, BMAX=3 instance.
    clear_logs();
    model_read(26'h3FFFFF8, 1);
    send_cmd(1'b1, 1, 26'h3FFFFF8);
    wait_idle();
    check_drained("t4");
    chk("t4_strobe_val", 128'(sobs1[0]), 128'd4);
    chk("t4_reqs", 128'(obs1.size()), 128'd2);
    chk("t4_size_r0", 128'(obs1[0].size), 128'd3);
    chk("t4_size_r1", 128'(obs1[1].size), 128'd1);
    chk("t4_addr_wrap", 128'(obs1[1].addr), 128'h0);

    // 5: zero-length read and write are dropped.
    sc = strobe_cnt[0];
    dc = done_cnt[0];
    send_cmd(1'b1, 0, 26'h40);
    chk("t5_rd_idle", 128'(busy_o[0]), 128'h0);
    send_cmd(1'b0, 0, 26'h80);
    chk("t5_wr_idle", 128'(busy_o[0]), 128'h0);
    repeat (4) @(negedge ddr2_clk);
    chk("t5_no_strobe", 128'(strobe_cnt[0] - sc), 128'd0);
    chk("t5_no_xfer", 128'(done_cnt[0] - dc), 128'd0);
    chk("t5_data_ready", 128'(data_rdy[0]), 128'h0);

    // 6: reset while a beat is stalled, then a fresh write.
    local_ready = 1'b0;
    wbuf[0] = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    model_write(26'h500, 1);
    send_cmd(1'b0, 1, 26'h500);
    send_word(wbuf[0]);
    chk("t6_in_beat", 128'(wr_o[0]), 128'h1);
    sys_rst_n = 1'b0;
    exp0.delete(); exp1.delete(); sexp0.delete(); sexp1.delete();
    @(posedge ddr2_clk);
    #1;
    chk("t6_rst_outputs",
        128'({wr_o[0], rd_o[0], bb_o[0], busy_o[0], cmd_rdy[0], data_rdy[0], rsz_stb[0]}), 128'h0);
    chk("t6_rst_addr", 128'(addr_o[0]), 128'h0);
    chk("t6_rst_data", 128'({wdata_o[0], be_o[0], size_o[0], rsz[0]}), 128'h0);
    @(negedge ddr2_clk);
    sys_rst_n = 1'b1;
    local_ready = 1'b1;
    clear_logs();
    wbuf[0] = 128'h01020304_05060708_090a0b0c_0d0e0f10;
    model_write(26'h600, 1);
    send_cmd(1'b0, 1, 26'h600);
    send_word(wbuf[0]);
    wait_idle();
    check_drained("t6");
    chk("t6_beats", 128'(obs0.size()), 128'd4);
    chk("t6_addr", 128'(obs0[0].addr), 128'h600);
    chk("t6_data_b0", 128'(obs0[0].data), 128'h01020304);

    repeat (2) @(negedge ddr2_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
